atmos_light_est: RTL and testbench

Per-frame atmospheric-light estimator for the dehaze pipeline. It consumes the dark-channel pixel stream with its sync/enable signals and tracks the brightest active dark-channel value over each frame. At every frame boundary it clamps that value, optionally smooths it, and latches it as the 8-bit atmospheric light. The output feeds directly into the `dark_max` input of the downstream defogging stage, so that stage always sees a value that is constant for a whole frame and never zero.

---
 rtl/atmos_pkg.sv | 29 ++
 rtl/atmos_iir.sv | 32 +++
 rtl/atmos_light_est.sv | 152 +++++++++++++++
 tb/tb_atmos_light_est.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atmos_pkg.sv
// Shared types, widths and helpers for the atmospheric-light estimator.
package atmos_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 24;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        UPDATE     = 2'd2
    } atmos_state_t;

    function automatic logic [PIX_W-1:0] clamp8(
        input logic [PIX_W-1:0] v,
        input logic [PIX_W-1:0] lo,
        input logic [PIX_W-1:0] hi
    );
        logic [PIX_W-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/atmos_iir.sv
// First-order smoothing of the clamped estimate; only built when ATMOS_IIR_EN is defined.
`ifdef ATMOS_IIR_EN
import atmos_pkg::*;

module atmos_iir #(
    parameter int IIR_SHIFT = 2
) (
    input  logic [PIX_W-1:0] cand,
    input  logic [PIX_W-1:0] cur,
    input  logic             primed,
    output logic [PIX_W-1:0] nxt
);

    logic signed [PIX_W:0] diff_s;
    logic signed [PIX_W:0] step_s;
    logic [PIX_W-1:0]      sum_s;
    logic                  sum_unused_s;

    // The step lies between cur and cand, so the 8-bit sum never wraps.
    always_comb begin
        diff_s = $signed({1'b0, cand}) - $signed({1'b0, cur});
        step_s = diff_s >>> IIR_SHIFT;
        {sum_unused_s, sum_s} = {1'b0, cur} + step_s;
        if (primed) begin
            nxt = sum_s;
        end else begin
            nxt = cand;
        end
    end

endmodule
`endif

// File: rtl/atmos_light_est.sv
// Per-frame atmospheric-light estimator: frame maximum of the dark channel, clamped and latched
// at each vsync rising edge. Optional smoothing is enabled with macro ATMOS_IIR_EN.
import atmos_pkg::*;

module atmos_light_est #(
    parameter logic [7:0]  A_INIT    = 8'd220,
    parameter logic [7:0]  A_MIN     = 8'd128,
    parameter logic [7:0]  A_MAX     = 8'd250,
    parameter logic [23:0] MIN_PIX   = 24'd16,
    parameter int          IIR_SHIFT = 2
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] i_dark,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic [PIX_W-1:0] o_dark_max,
    output logic             o_update
);

    atmos_state_t     state_r, state_nxt_s;
    logic             vs_d_r;
    logic [PIX_W-1:0] run_max_r, run_max_nxt_s;
    logic [CNT_W-1:0] pix_cnt_r, pix_cnt_nxt_s;
    logic [PIX_W-1:0] dark_max_r, dark_max_nxt_s;
    logic             update_r, update_nxt_s;
    logic [PIX_W-1:0] cand_s;
    logic [PIX_W-1:0] accept_val_s;
    logic             bnd_s;
    logic             hsync_unused_s;

    assign hsync_unused_s = i_hsync | (IIR_SHIFT != 0);
    assign bnd_s          = i_vsync & ~vs_d_r;
    assign cand_s         = clamp8(run_max_r, A_MIN, A_MAX);

`ifdef ATMOS_IIR_EN
    logic primed_r, primed_nxt_s;

    atmos_iir #(.IIR_SHIFT(IIR_SHIFT)) u_iir (
        .cand   (cand_s),
        .cur    (dark_max_r),
        .primed (primed_r),
        .nxt    (accept_val_s)
    );

    // Primed flag: cleared by reset, set by the first accepted frame.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            primed_r <= 1'b0;
        end else begin
            primed_r <= primed_nxt_s;
        end
    end
`else
    assign accept_val_s = cand_s;
`endif

    // Next-state and datapath decisions for the frame FSM.
    always_comb begin
        state_nxt_s    = state_r;
        run_max_nxt_s  = run_max_r;
        pix_cnt_nxt_s  = pix_cnt_r;
        dark_max_nxt_s = dark_max_r;
        update_nxt_s   = 1'b0;
`ifdef ATMOS_IIR_EN
        primed_nxt_s   = primed_r;
`endif
        case (state_r)
            WAIT_FRAME: begin
                run_max_nxt_s = {PIX_W{1'b0}};
                pix_cnt_nxt_s = {CNT_W{1'b0}};
                if (bnd_s) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = WAIT_FRAME;
                end
            end
            ACCUM: begin
                if (i_de) begin
                    if (i_dark > run_max_r) begin
                        run_max_nxt_s = i_dark;
                    end else begin
                        run_max_nxt_s = run_max_r;
                    end
                    if (pix_cnt_r != {CNT_W{1'b1}}) begin
                        pix_cnt_nxt_s = pix_cnt_r + CNT_W'(1);
                    end else begin
                        pix_cnt_nxt_s = pix_cnt_r;
                    end
                end else begin
                    run_max_nxt_s = run_max_r;
                    pix_cnt_nxt_s = pix_cnt_r;
                end
                if (bnd_s) begin
                    state_nxt_s = UPDATE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            UPDATE: begin
                if (pix_cnt_r >= MIN_PIX) begin
                    dark_max_nxt_s = accept_val_s;
                    update_nxt_s   = 1'b1;
`ifdef ATMOS_IIR_EN
                    primed_nxt_s   = 1'b1;
`endif
                end else begin
                    dark_max_nxt_s = dark_max_r;
                    update_nxt_s   = 1'b0;
                end
                // The pixel sampled during UPDATE opens the new frame.
                if (i_de) begin
                    run_max_nxt_s = i_dark;
                    pix_cnt_nxt_s = CNT_W'(1);
                end else begin
                    run_max_nxt_s = {PIX_W{1'b0}};
                    pix_cnt_nxt_s = {CNT_W{1'b0}};
                end
                state_nxt_s = ACCUM;
            end
            default: begin
                state_nxt_s   = WAIT_FRAME;
                run_max_nxt_s = {PIX_W{1'b0}};
                pix_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WAIT_FRAME;
            vs_d_r     <= 1'b0;
            run_max_r  <= {PIX_W{1'b0}};
            pix_cnt_r  <= {CNT_W{1'b0}};
            dark_max_r <= A_INIT;
            update_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            vs_d_r     <= i_vsync;
            run_max_r  <= run_max_nxt_s;
            pix_cnt_r  <= pix_cnt_nxt_s;
            dark_max_r <= dark_max_nxt_s;
            update_r   <= update_nxt_s;
        end
    end

    assign o_dark_max = dark_max_r;
    assign o_update   = update_r;

endmodule

// File: tb/tb_atmos_light_est.sv
// Self-checking bench for atmos_light_est: frame table plus hand sequences, scoreboard on o_update.
module tb_atmos_light_est;

    logic       pixelclk;
    logic       reset_n;
    logic [7:0] i_dark;
    logic       i_hsync;
    logic       i_vsync;
    logic       i_de;
    logic [7:0] o_dark_max;
    logic       o_update;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_dm;
    logic [7:0] exp_q[$];

    typedef struct {
        int         npix;
        logic [7:0] base;
        logic [7:0] peak;
        logic       acc;
        logic [7:0] dm;
    } vec_t;

    vec_t tbl[9];

    atmos_light_est dut (
        .pixelclk   (pixelclk),
        .reset_n    (reset_n),
        .i_dark     (i_dark),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_de       (i_de),
        .o_dark_max (o_dark_max),
        .o_update   (o_update)
    );

    initial begin
        pixelclk = 1'b0;
        forever #5 pixelclk = ~pixelclk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every o_update pulse must match a queued expectation.
    always @(negedge pixelclk) begin
        if (o_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_update", 1, 0);
            end else begin
                chk("sb_dark_max", o_dark_max, exp_q.pop_front());
            end
        end
    end

    task automatic frame(input int npix, input logic [7:0] base, input logic [7:0] peak);
        for (int i = 0; i < npix; i++) begin
            if (i % 8 == 0) begin
                @(posedge pixelclk) #1;
                i_de = 1'b0; i_dark = 8'd255; i_hsync = 1'b1;
            end
            @(posedge pixelclk) #1;
            i_hsync = 1'b0;
            i_de    = 1'b1;
            i_dark  = (i == npix / 2) ? peak : base;
        end
        @(posedge pixelclk) #1;
        i_de = 1'b0; i_dark = 8'd0;
        @(negedge pixelclk);
        chk("hold_active", o_dark_max, exp_dm);
        chk("no_update_active", o_update, 0);
    endtask

    task automatic vsync(input logic bde, input logic [7:0] bdark,
                         input logic ude, input logic [7:0] udark,
                         input logic acc, input logic [7:0] dm);
        @(posedge pixelclk) #1;
        i_vsync = 1'b1; i_de = bde; i_dark = bdark;
        @(negedge pixelclk);
        if (acc) exp_q.push_back(dm);
        @(posedge pixelclk) #1;
        i_de = ude; i_dark = udark;
        @(negedge pixelclk);
        chk("upd_early", o_update, 0);
        @(posedge pixelclk) #1;
        i_de = 1'b0; i_dark = 8'd0;
        @(negedge pixelclk);
        chk("upd_pulse", o_update, acc);
        chk("upd_value", o_dark_max, dm);
        exp_dm = dm;
        @(posedge pixelclk) #1;
        @(negedge pixelclk);
        chk("upd_one_cycle", o_update, 0);
        @(posedge pixelclk) #1;
        i_vsync = 1'b0;
    endtask

    initial begin
`ifdef ATMOS_IIR_EN
        tbl[0] = '{100, 8'd90,  8'd200, 1'b1, 8'd200};
        tbl[1] = '{100, 8'd90,  8'd240, 1'b1, 8'd210};
        tbl[2] = '{50,  8'd30,  8'd100, 1'b1, 8'd189};
        tbl[3] = '{50,  8'd30,  8'd60,  1'b1, 8'd173};
        tbl[4] = '{50,  8'd100, 8'd255, 1'b1, 8'd192};
        tbl[5] = '{10,  8'd50,  8'd200, 1'b0, 8'd192};
        tbl[6] = '{16,  8'd10,  8'd170, 1'b1, 8'd186};
        tbl[7] = '{15,  8'd10,  8'd180, 1'b0, 8'd186};
        tbl[8] = '{16,  8'd10,  8'd189, 1'b1, 8'd186};
`else
        tbl[0] = '{100, 8'd90,  8'd200, 1'b1, 8'd200};
        tbl[1] = '{100, 8'd90,  8'd240, 1'b1, 8'd240};
        tbl[2] = '{50,  8'd30,  8'd100, 1'b1, 8'd128};
        tbl[3] = '{50,  8'd30,  8'd60,  1'b1, 8'd128};
        tbl[4] = '{50,  8'd100, 8'd255, 1'b1, 8'd250};
        tbl[5] = '{10,  8'd50,  8'd200, 1'b0, 8'd250};
        tbl[6] = '{16,  8'd10,  8'd170, 1'b1, 8'd170};
        tbl[7] = '{15,  8'd10,  8'd180, 1'b0, 8'd170};
        tbl[8] = '{16,  8'd10,  8'd189, 1'b1, 8'd189};
`endif
        reset_n = 1'b0; i_dark = 8'd0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
        exp_dm  = 8'd220;
        repeat (3) @(posedge pixelclk);
        #1 reset_n = 1'b1;
        @(negedge pixelclk);
        chk("rst_dark_max", o_dark_max, 220);
        chk("rst_update", o_update, 0);

        // Frame before the first boundary is ignored; first boundary only primes.
        frame(100, 8'd240, 8'd245);
        vsync(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd220);

        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].npix, tbl[i].base, tbl[i].peak);
            vsync(1'b0, 8'd0, 1'b0, 8'd0, tbl[i].acc, tbl[i].dm);
        end

        // Boundary-cycle pixel closes the old frame; UPDATE-cycle pixel opens the new one.
        frame(20, 8'd150, 8'd150);
`ifdef ATMOS_IIR_EN
        vsync(1'b1, 8'd249, 1'b1, 8'd245, 1'b1, 8'd201);
        frame(20, 8'd100, 8'd100);
        vsync(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd212);
`else
        vsync(1'b1, 8'd249, 1'b1, 8'd245, 1'b1, 8'd249);
        frame(20, 8'd100, 8'd100);
        vsync(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd245);
`endif

        // Mid-frame reset pulse.
        for (int i = 0; i < 10; i++) begin
            @(posedge pixelclk) #1;
            i_de = 1'b1; i_dark = 8'd200;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_dark_max", o_dark_max, 220);
        chk("midrst_update", o_update, 0);
        @(posedge pixelclk) #1;
        reset_n = 1'b1;
        exp_dm  = 8'd220;
        frame(30, 8'd240, 8'd240);
        vsync(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd220);
        frame(40, 8'd50, 8'd230);
        vsync(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd230);

        repeat (4) @(posedge pixelclk);
        @(negedge pixelclk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
